video_format_detector: RTL and testbench
========================================

// Module: video_format_detector
// PURPOSE
// Measures separated H/V sync timing of the incoming analogue video and classifies it into the 8-bit
// format code consumed by the monitor slot interface (reg 0x31): 0x00 none, 0x01 576i50, 0x02 480i60,
// 0x03 576p50, 0x04 480p60. Sits upstream of the slot interface; runs entirely on clk_50mhz_in.
// PARAMETERS
// STABLE_FIELDS  4          consecutive identical field classifications required before output updates (1..15)
// TIMEOUT_CLKS   2_500_000  clocks without a vsync leading edge before declaring no signal (50 ms)
// REJECT_MAX     32         rejected short hsync edges per field above which line-rate lock is dropped
// HSYNC_POL      0          0 = hsync_in active-low, 1 = active-high
// VSYNC_POL      0          0 = vsync_in active-low, 1 = active-high
// PORTS
// clk_50mhz_in    in   1  50 MHz system clock
// reset_x         in   1  asynchronous, active-low reset
// hsync_in        in   1  horizontal sync, asynchronous to clock
// vsync_in        in   1  vertical sync, asynchronous to clock
// video_format    out  8  stable format code (values above)
// format_valid    out  1  1 while video_format != 0x00
// format_changed  out  1  one-clock pulse whenever video_format changes value
// BEHAVIOUR
// - Reset (reset_x=0, any time): all outputs 0, all counters/latches 0, match count 0; measurement restarts.
// - Sync inputs: 2-FF synchronisers, polarity normalised, leading-edge (inactive->active) pulse 3 clocks after pin.
// - hcnt[11:0]: +1 per clock, saturates at 4095. On an hsync edge: if hper==0 or hcnt >= hper-(hper>>2)
//   the edge is accepted: hper<=hcnt, hcnt<=1, line counter +1 (11 bit, saturates 2047). Otherwise the
//   edge is rejected (equalising/half-line pulse), hcnt keeps counting, reject counter +1 (saturating).
// - Rate: hper 3100..3300 -> 15k; 1550..1650 -> 31k; any other value -> invalid.
// - On a vsync edge: lines = line counter (+1 if an accepted hsync edge occurs the same cycle);
//   candidate = 15k&300..330 ->0x01, 15k&250..280 ->0x02, 31k&600..650 ->0x03, 31k&500..550 ->0x04, else 0x00.
//   If rejects > REJECT_MAX: candidate forced 0x00 and hper cleared to 0 (re-acquire line rate).
//   Then line counter and reject counter cleared, watchdog cleared.
// - Stability: candidate==previous candidate -> match count +1 (saturates at STABLE_FIELDS), else match count=1.
//   When match count==STABLE_FIELDS and candidate!=video_format: video_format<=candidate (registered, 1 clock
//   after the vsync edge), format_changed pulses that same cycle. format_valid = (video_format!=0).
// - Interlace: 312/313 and 262/263 alternating field lengths both fall in range; treated as identical candidate.
// - Watchdog: 22-bit counter, cleared on vsync edge; at TIMEOUT_CLKS: hper<=0, match count<=0, line/reject
//   counters<=0, video_format<=0x00; format_changed pulses only if the value was non-zero. Watchdog then holds.
// - No glitch path: outputs are registered; format code never passes through an intermediate value.
// CONFIGURATION
// VIDEO_FMT_MEASURE_OUT_EN defined: extra outputs line_period[11:0] (= hper) and lines_per_field[10:0]
//   (lines latched at last vsync edge), reset 0, for the slot interface debug register / bring-up.
// Not defined: those ports and their registers do not exist; classification behaviour identical.
// TESTING
// 1. hsync period 3200 clk, fields alternating 312/313 lines, 5 equalising pulses at half-line near vsync
//    -> video_format=0x01 after 4th field, format_valid=1, single format_changed pulse.
// 2. hsync 1589 clk, 525 lines/field -> video_format=0x04 after 4 fields; steady for 20 further fields, no pulses.
// 3. Switch 0x01 stream to 480p stream without gap -> hper re-acquired via reject threshold, output goes
//    directly 0x01->0x04 (never 0x02/0x03), exactly one pulse.
// 4. Stop vsync while hsync continues -> 2_500_000 clk after last vsync edge video_format=0x00, valid=0, one pulse.
// 5. 3 good 576p fields, 1 field of 400 lines, 3 good fields -> video_format stays 0x00, no pulse.
// 6. Assert reset_x low mid-field while 0x03 locked -> outputs 0 immediately; relock after 4 fields post-release.

Source files
------------

// File: rtl/video_format_detector.sv
// video_format_detector
// Measures separated H/V sync timing of incoming analogue video and classifies
// each field into an 8-bit format code (0x00 none, 0x01 576i50, 0x02 480i60,
// 0x03 576p50, 0x04 480p60). A code is published only after STABLE_FIELDS
// identical consecutive field classifications. A watchdog forces "none" when
// vsync disappears.
// Optional build macro VIDEO_FMT_MEASURE_OUT_EN adds the raw measurement
// outputs line_period and lines_per_field for bring-up.
// The H*_MIN/H*_MAX parameters are the line-period windows in clocks; the
// defaults match a 50 MHz clock.
module video_format_detector #(
   parameter int STABLE_FIELDS = 4,
   parameter int TIMEOUT_CLKS  = 2_500_000,
   parameter int REJECT_MAX    = 32,
   parameter bit HSYNC_POL     = 1'b0,
   parameter bit VSYNC_POL     = 1'b0,
   parameter int H15_MIN       = 3100,
   parameter int H15_MAX       = 3300,
   parameter int H31_MIN       = 1550,
   parameter int H31_MAX       = 1650
) (
   input  logic        clk_50mhz_in,
   input  logic        reset_x,
   input  logic        hsync_in,
   input  logic        vsync_in,
   output logic [7:0]  video_format,
   output logic        format_valid,
   output logic        format_changed
`ifdef VIDEO_FMT_MEASURE_OUT_EN
   ,
   output logic [11:0] line_period,
   output logic [10:0] lines_per_field
`endif
);

   localparam int               REJ_W        = $clog2(REJECT_MAX + 2);
   localparam logic [REJ_W-1:0] L_REJ_MAX    = REJ_W'(REJECT_MAX);
   localparam logic [21:0]      L_TIMEOUT    = 22'(TIMEOUT_CLKS);
   localparam logic [21:0]      L_TIMEOUT_M1 = 22'(TIMEOUT_CLKS - 1);
   localparam logic [3:0]       L_STABLE     = 4'(STABLE_FIELDS);
   localparam logic [11:0]      L_H15_MIN    = 12'(H15_MIN);
   localparam logic [11:0]      L_H15_MAX    = 12'(H15_MAX);
   localparam logic [11:0]      L_H31_MIN    = 12'(H31_MIN);
   localparam logic [11:0]      L_H31_MAX    = 12'(H31_MAX);

   // Map measured line period and line count onto a format code.
   function automatic logic [7:0] f_classify(input logic [11:0] hper,
                                             input logic [10:0] lines);
      logic is15;
      logic is31;
      is15 = (hper >= L_H15_MIN) && (hper <= L_H15_MAX);
      is31 = (hper >= L_H31_MIN) && (hper <= L_H31_MAX);
      if (is15 && lines >= 11'd300 && lines <= 11'd330)      return 8'h01;
      else if (is15 && lines >= 11'd250 && lines <= 11'd280) return 8'h02;
      else if (is31 && lines >= 11'd600 && lines <= 11'd650) return 8'h03;
      else if (is31 && lines >= 11'd500 && lines <= 11'd550) return 8'h04;
      else                                                   return 8'h00;
   endfunction

   logic [2:0]       r_hs_sync;
   logic [2:0]       r_vs_sync;
   logic             r_hs_edge;
   logic             r_vs_edge;
   logic [11:0]      r_hcnt;
   logic [11:0]      r_hper;
   logic [10:0]      r_lcnt;
   logic [REJ_W-1:0] r_rej;
   logic [21:0]      r_wd;
   logic [7:0]       r_prev_cand;
   logic [3:0]       r_match;
   logic [7:0]       r_fmt;
   logic             r_valid;
   logic             r_chg;

   logic             w_hs_act;
   logic             w_hs_act_d;
   logic             w_vs_act;
   logic             w_vs_act_d;
   logic [11:0]      w_hthr;
   logic             w_h_acc;
   logic             w_h_rej;
   logic [10:0]      w_lcnt_inc;
   logic [10:0]      w_lines;
   logic             w_rej_over;
   logic [7:0]       w_cand;
   logic [3:0]       w_match_next;
   logic             w_timeout;

   // Polarity-normalised "active" views of the synchronised sync pins.
   assign w_hs_act   = HSYNC_POL ? r_hs_sync[1] : ~r_hs_sync[1];
   assign w_hs_act_d = HSYNC_POL ? r_hs_sync[2] : ~r_hs_sync[2];
   assign w_vs_act   = VSYNC_POL ? r_vs_sync[1] : ~r_vs_sync[1];
   assign w_vs_act_d = VSYNC_POL ? r_vs_sync[2] : ~r_vs_sync[2];

   // Edges arriving before 3/4 of the locked period are equalising or
   // half-line pulses and must not count as lines.
   assign w_hthr     = r_hper - (r_hper >> 2);
   assign w_h_acc    = r_hs_edge & ((r_hper == 12'd0) | (r_hcnt >= w_hthr));
   assign w_h_rej    = r_hs_edge & ~w_h_acc;
   assign w_lcnt_inc = (r_lcnt == 11'h7FF) ? r_lcnt : r_lcnt + 11'd1;
   assign w_lines    = w_h_acc ? w_lcnt_inc : r_lcnt;
   assign w_rej_over = r_rej > L_REJ_MAX;
   assign w_cand     = w_rej_over ? 8'h00 : f_classify(r_hper, w_lines);
   assign w_match_next = (w_cand != r_prev_cand) ? 4'd1 :
                         (r_match >= L_STABLE)    ? L_STABLE : r_match + 4'd1;
   assign w_timeout  = ~r_vs_edge & (r_wd == L_TIMEOUT_M1);

   // Two-flop synchronisers plus one history flop; registered leading-edge pulses.
   always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
      if (!reset_x) begin
         r_hs_sync <= '0;
         r_vs_sync <= '0;
         r_hs_edge <= 1'b0;
         r_vs_edge <= 1'b0;
      end else begin
         r_hs_sync <= {r_hs_sync[1:0], hsync_in};
         r_vs_sync <= {r_vs_sync[1:0], vsync_in};
         r_hs_edge <= w_hs_act & ~w_hs_act_d;
         r_vs_edge <= w_vs_act & ~w_vs_act_d;
      end
   end

   // Line-period measurement, per-field line/reject counting and vsync watchdog.
   always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
      if (!reset_x) begin
         r_hcnt <= '0;
         r_hper <= '0;
         r_lcnt <= '0;
         r_rej  <= '0;
         r_wd   <= '0;
      end else begin
         if (w_h_acc)                  r_hcnt <= 12'd1;
         else if (r_hcnt != 12'hFFF)   r_hcnt <= r_hcnt + 12'd1;

         if (w_timeout || (r_vs_edge && w_rej_over)) r_hper <= '0;
         else if (w_h_acc)                           r_hper <= r_hcnt;

         if (w_timeout || r_vs_edge)   r_lcnt <= '0;
         else if (w_h_acc)             r_lcnt <= w_lcnt_inc;

         if (w_timeout || r_vs_edge)   r_rej <= '0;
         else if (w_h_rej && r_rej != '1) r_rej <= r_rej + 1'b1;

         if (r_vs_edge)                r_wd <= '0;
         else if (r_wd != L_TIMEOUT)   r_wd <= r_wd + 22'd1;
      end
   end

   // Field-to-field stability filter and registered format outputs.
   always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
      if (!reset_x) begin
         r_prev_cand <= '0;
         r_match     <= '0;
         r_fmt       <= '0;
         r_valid     <= 1'b0;
         r_chg       <= 1'b0;
      end else begin
         r_chg <= 1'b0;
         if (w_timeout) begin
            r_match <= '0;
            r_fmt   <= '0;
            r_valid <= 1'b0;
            r_chg   <= (r_fmt != 8'h00);
         end else if (r_vs_edge) begin
            r_prev_cand <= w_cand;
            r_match     <= w_match_next;
            if (w_match_next == L_STABLE && w_cand != r_fmt) begin
               r_fmt   <= w_cand;
               r_valid <= (w_cand != 8'h00);
               r_chg   <= 1'b1;
            end
         end
      end
   end

   assign video_format   = r_fmt;
   assign format_valid   = r_valid;
   assign format_changed = r_chg;

`ifdef VIDEO_FMT_MEASURE_OUT_EN
   logic [10:0] r_lines_lat;

   // Hold the line count of the most recently completed field for readback.
   always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
      if (!reset_x)       r_lines_lat <= '0;
      else if (r_vs_edge) r_lines_lat <= w_lines;
   end

   assign line_period     = r_hper;
   assign lines_per_field = r_lines_lat;
`endif

endmodule

// File: tb/tb_video_format_detector.sv
// Bench for video_format_detector. Line periods are scaled down (15 kHz class
// = 8 clocks, 31 kHz class = 4 clocks) through the period-window parameters so
// whole fields fit a short run; line counts per field are the real ones.
module tb_video_format_detector;

   logic       clk_50mhz_in = 1'b0;
   logic       reset_x;
   logic       hsync_in;
   logic       vsync_in;
   logic [7:0] video_format;
   logic       format_valid;
   logic       format_changed;
`ifdef VIDEO_FMT_MEASURE_OUT_EN
   logic [11:0] line_period;
   logic [10:0] lines_per_field;
`endif

   always #5 clk_50mhz_in = ~clk_50mhz_in;

   video_format_detector #(
      .STABLE_FIELDS (4),
      .TIMEOUT_CLKS  (4000),
      .REJECT_MAX    (32),
      .HSYNC_POL     (1'b0),
      .VSYNC_POL     (1'b0),
      .H15_MIN       (7),
      .H15_MAX       (9),
      .H31_MIN       (3),
      .H31_MAX       (5)
   ) dut (
      .clk_50mhz_in   (clk_50mhz_in),
      .reset_x        (reset_x),
      .hsync_in       (hsync_in),
      .vsync_in       (vsync_in),
      .video_format   (video_format),
      .format_valid   (format_valid),
      .format_changed (format_changed)
`ifdef VIDEO_FMT_MEASURE_OUT_EN
      ,
      .line_period    (line_period),
      .lines_per_field(lines_per_field)
`endif
   );

   int         n_cmp   = 0;
   int         n_bad   = 0;
   int         n_push  = 0;
   int         n_pulse = 0;
   logic [7:0] exp_q[$];
   logic [7:0] e_val;

   typedef struct {
      int         hper;
      int         nlines;
      int         neq;
      logic [7:0] exp_fmt;
      bit         pulse;
   } row_t;

   row_t rows[22];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%02h, wanted 0x%02h", name, act, exp);
      end
   endtask

   // One field: vsync mid-way through line 0, equalising pulses at half-line
   // in lines 1..neq. Sync pins are active-low.
   task automatic drive_field(input int hper, input int nlines, input int neq, input bit with_vs);
      for (int l = 0; l < nlines; l++) begin
         for (int c = 0; c < hper; c++) begin
            @(negedge clk_50mhz_in);
            hsync_in = !((c < 2) ||
                         (l >= 1 && l <= neq && c >= hper / 2 && c < hper / 2 + 2));
            vsync_in = !(with_vs && l == 0 && c >= hper / 2 && c < hper / 2 + 2);
         end
      end
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         if (rows[i].pulse) begin
            exp_q.push_back(rows[i].exp_fmt);
            n_push++;
         end
         drive_field(rows[i].hper, rows[i].nlines, rows[i].neq, 1'b1);
         chk($sformatf("row%0d_format", i), video_format, rows[i].exp_fmt);
         chk($sformatf("row%0d_valid", i), {7'd0, format_valid},
             {7'd0, (rows[i].exp_fmt != 8'h00)});
      end
   endtask

   // Scoreboard: every format_changed pulse must match the next pending change.
   always @(negedge clk_50mhz_in) begin
      if (reset_x === 1'b1 && format_changed === 1'b1) begin
         n_pulse++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pulse: format_changed=1 video_format=0x%02h, wanted no pulse",
                     video_format);
         end else begin
            e_val = exp_q.pop_front();
            chk("pulse_value", video_format, e_val);
         end
      end
   end

   initial begin
      reset_x  = 1'b0;
      hsync_in = 1'b1;
      vsync_in = 1'b1;

      // 576i: 312/313 alternating with equalising pulses; locks on the 5th vsync
      rows[0]  = '{8, 312, 5, 8'h00, 1'b0};
      rows[1]  = '{8, 313, 5, 8'h00, 1'b0};
      rows[2]  = '{8, 312, 5, 8'h00, 1'b0};
      rows[3]  = '{8, 313, 5, 8'h00, 1'b0};
      rows[4]  = '{8, 312, 5, 8'h01, 1'b1};
      // 480p steady after lock: no further pulses
      rows[5]  = '{4, 525, 0, 8'h04, 1'b0};
      rows[6]  = '{4, 525, 0, 8'h04, 1'b0};
      rows[7]  = '{4, 525, 0, 8'h04, 1'b0};
      // 576p with one 400-line field breaking the run, then lock to 0x03
      rows[8]  = '{4, 625, 0, 8'h00, 1'b0};
      rows[9]  = '{4, 625, 0, 8'h00, 1'b0};
      rows[10] = '{4, 625, 0, 8'h00, 1'b0};
      rows[11] = '{4, 400, 0, 8'h00, 1'b0};
      rows[12] = '{4, 625, 0, 8'h00, 1'b0};
      rows[13] = '{4, 625, 0, 8'h00, 1'b0};
      rows[14] = '{4, 625, 0, 8'h00, 1'b0};
      rows[15] = '{4, 625, 0, 8'h00, 1'b0};
      rows[16] = '{4, 625, 0, 8'h03, 1'b1};
      // relock to 576p after a mid-field reset
      rows[17] = '{4, 625, 0, 8'h00, 1'b0};
      rows[18] = '{4, 625, 0, 8'h00, 1'b0};
      rows[19] = '{4, 625, 0, 8'h00, 1'b0};
      rows[20] = '{4, 625, 0, 8'h00, 1'b0};
      rows[21] = '{4, 625, 0, 8'h03, 1'b1};

      repeat (5) @(negedge clk_50mhz_in);
      chk("reset_format", video_format, 8'h00);
      chk("reset_valid", {7'd0, format_valid}, 8'h00);
      chk("reset_changed", {7'd0, format_changed}, 8'h00);
      reset_x = 1'b1;

      run_rows(0, 4);

      // 576i -> 480p with no gap: single direct change to 0x04, bounded wait
      exp_q.push_back(8'h04);
      n_push++;
      for (int k = 0; k < 10 && video_format !== 8'h04; k++)
         drive_field(4, 525, 0, 1'b1);
      chk("switch_to_480p", video_format, 8'h04);
      chk("switch_valid", {7'd0, format_valid}, 8'h01);

      run_rows(5, 7);

      // vsync lost, hsync continues: drop to 0x00 once the watchdog expires
      exp_q.push_back(8'h00);
      n_push++;
      drive_field(4, 400, 0, 1'b0);
      chk("before_timeout", video_format, 8'h04);
      drive_field(4, 200, 0, 1'b0);
      chk("after_timeout", video_format, 8'h00);
      chk("after_timeout_valid", {7'd0, format_valid}, 8'h00);

      run_rows(8, 16);

      // reset mid-field while 0x03 is locked
      drive_field(4, 300, 0, 1'b0);
      chk("before_reset", video_format, 8'h03);
      @(negedge clk_50mhz_in);
      reset_x = 1'b0;
      #1;
      chk("midreset_format", video_format, 8'h00);
      chk("midreset_valid", {7'd0, format_valid}, 8'h00);
      chk("midreset_changed", {7'd0, format_changed}, 8'h00);
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      repeat (4) @(negedge clk_50mhz_in);
      reset_x = 1'b1;

      run_rows(17, 21);

      repeat (10) @(negedge clk_50mhz_in);
      chk("pending_changes", 8'(exp_q.size()), 8'd0);
      chk("pulse_count", 8'(n_pulse), 8'(n_push));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
